min_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the MIN execution unit.
- Maintains the fetch PC and issues 16-bit word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch queue and presents the head word (irf) and its address to the execute stage with a valid/ready handshake.
- Accepts branch redirects from execute: flushes the queue, drains any in-flight read, and restarts fetch at the new PC.

---
 rtl/min_pkg.sv | 16 +
 rtl/min_fetch_unit_if.sv | 29 ++
 rtl/min_prefetch_fifo.sv | 69 ++++++
 rtl/min_fetch_unit.sv | 125 ++++++++++++
 tb/tb_min_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/min_pkg.sv
// rtl/min_pkg.sv - shared width, reset address and fetch state encoding for the MIN fetch stage
package min_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/min_fetch_unit_if.sv
// rtl/min_fetch_unit_if.sv - memory, redirect and execute handshakes of the fetch stage
interface min_fetch_unit_if;
  import min_pkg::*;

  logic  mem_req;
  word_t mem_addr;
  logic  mem_ack;
  word_t mem_rdata;
  logic  redirect;
  word_t redirect_pc;
  word_t irf;
  logic  irf_valid;
  logic  ire_ready;
  word_t ire_pc;
  word_t pc;

  // fetch unit side
  modport master (
    output mem_req, mem_addr, irf, irf_valid, ire_pc, pc,
    input  mem_ack, mem_rdata, redirect, redirect_pc, ire_ready
  );

  // memory / execute side
  modport slave (
    input  mem_req, mem_addr, irf, irf_valid, ire_pc, pc,
    output mem_ack, mem_rdata, redirect, redirect_pc, ire_ready
  );

endinterface

// File: rtl/min_prefetch_fifo.sv
// rtl/min_prefetch_fifo.sv - circular prefetch queue of instruction words tagged with their address
module min_prefetch_fifo
  import min_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  word_t         push_data,
  input  word_t         push_tag,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          empty,
  output word_t         head_data,
  output word_t         head_tag
);

  word_t         data_mem [DEPTH];
  word_t         tag_mem  [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign head_data = data_mem[rd_ptr];
  assign head_tag  = tag_mem[rd_ptr];

  // storage and pointers; storage is cleared at reset so the head reads zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        tag_mem[wr_ptr]  <= push_tag;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // the fetch FSM stops requesting before the queue can overflow
  always_ff @(posedge clk) begin
    if (reset && push && !flush) begin
      assert (!full);
    end
  end

endmodule

// File: rtl/min_fetch_unit.sv
// rtl/min_fetch_unit.sv - fetch PC, instruction memory read handshake and redirect handling
module min_fetch_unit
  import min_pkg::*;
#(
  parameter int    DEPTH    = 2,
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  min_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_FULL  = FULL;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]    state;
  word_t         pc_q;
  word_t         pc_next;
  logic          req_q;
  word_t         addr_q;
  logic          acked;
  logic          pop;
  logic          push;
  logic          fills_up;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  word_t         head_data;
  word_t         head_tag;

  // an ack only counts while a read is actually outstanding
  assign acked    = req_q & bus.mem_ack;
  assign pop      = ~fifo_empty & bus.ire_ready;
  assign push     = (state == S_FETCH) & acked & ~bus.redirect;
  assign pc_next  = pc_q + 16'd1;
  // the word being accepted takes the last free slot unless the head leaves too
  assign fills_up = (fifo_count == CW'(DEPTH - 1)) & ~pop;

  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.pc        = pc_q;
  assign bus.irf       = head_data;
  assign bus.ire_pc    = head_tag;
  assign bus.irf_valid = ~fifo_empty;

  min_prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.mem_rdata),
    .push_tag  (addr_q),
    .pop       (pop),
    .flush     (bus.redirect),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head_data (head_data),
    .head_tag  (head_tag)
  );

  // fetch FSM: request issue, pc advance, redirect and stale-read draining
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_FETCH;
      pc_q   <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.redirect) begin
            pc_q <= bus.redirect_pc;
            if (req_q && !bus.mem_ack) begin
              // read still in flight: keep the request stable until it returns
              state <= S_DRAIN;
            end else begin
              req_q  <= 1'b1;
              addr_q <= bus.redirect_pc;
            end
          end else if (acked) begin
            pc_q <= pc_next;
            if (fills_up) begin
              state <= S_FULL;
              req_q <= 1'b0;
            end else begin
              req_q  <= 1'b1;
              addr_q <= pc_next;
            end
          end else if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= pc_q;
          end
        end
        S_FULL: begin
          if (bus.redirect) begin
            state  <= S_FETCH;
            pc_q   <= bus.redirect_pc;
            req_q  <= 1'b1;
            addr_q <= bus.redirect_pc;
          end else if (pop) begin
            state <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (bus.redirect) begin
            pc_q <= bus.redirect_pc;
          end
          if (acked) begin
            // stale data is dropped; request continues at the newest target
            state  <= S_FETCH;
            addr_q <= bus.redirect ? bus.redirect_pc : pc_q;
          end
        end
        default: begin
          state <= S_FETCH;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_min_fetch_unit.sv
// tb/tb_min_fetch_unit.sv - randomized self-checking bench for min_fetch_unit
module tb_min_fetch_unit;
  import min_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  min_fetch_unit_if bus();

  min_fetch_unit #(
    .DEPTH    (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] data_off  = 16'h0400;
  int          mem_lat   = 0;
  int          mem_wait  = 0;
  bit          rand_lat  = 0;
  bit          stray_ack = 0;

  logic        o_req = 0, o_valid = 0;
  logic [15:0] o_addr = 0, o_irf = 0, o_irepc = 0, o_pc = 0;

  logic [15:0] got_data[$];
  logic [15:0] got_pc[$];
  logic [15:0] ack_addr[$];

  // one clock: memory responds from the last sampled request, pops/acks are logged
  task automatic step();
    if (!reset) begin
      mem_wait    = 0;
      bus.mem_ack = 1'b0;
    end else if (o_req) begin
      if (mem_wait >= mem_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = o_addr + data_off;
        mem_wait      = 0;
      end else begin
        bus.mem_ack = 1'b0;
        mem_wait++;
      end
    end else begin
      bus.mem_ack   = stray_ack;
      bus.mem_rdata = 16'($urandom);
    end
    @(posedge clk);
    if (reset) begin
      if (o_valid && bus.ire_ready) begin
        got_data.push_back(o_irf);
        got_pc.push_back(o_irepc);
      end
      if (o_req && bus.mem_ack) begin
        ack_addr.push_back(o_addr);
        if (rand_lat) mem_lat = int'($urandom_range(0, 2));
      end
    end
    @(negedge clk);
    o_req   = bus.mem_req;
    o_addr  = bus.mem_addr;
    o_valid = bus.irf_valid;
    o_irf   = bus.irf;
    o_irepc = bus.ire_pc;
    o_pc    = bus.pc;
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.ire_ready   = 1'b0;
    stray_ack       = 1'b0;
    step();
    reset = 1'b1;
    got_data.delete();
    got_pc.delete();
    ack_addr.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0h expected 0", o_req); end
    n_checks++; if (o_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", o_addr); end
    n_checks++; if (o_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", o_pc); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_irf_valid: got %0h expected 0", o_valid); end
    n_checks++; if (o_irf !== 16'h0000) begin n_fail++; $display("FAIL reset_irf: got %h expected 0000", o_irf); end
    n_checks++; if (o_irepc !== 16'h0000) begin n_fail++; $display("FAIL reset_ire_pc: got %h expected 0000", o_irepc); end
  endtask

  task automatic test_stream();
    data_off = 16'h0400; mem_lat = 0; rand_lat = 0;
    do_reset();
    bus.ire_ready = 1'b1;
    step();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 16'h0000) begin n_fail++; $display("FAIL stream_first_req: got req %0h addr %h expected req 1 addr 0000", o_req, o_addr); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_early: got %0h expected 0", o_valid); end
    step();
    n_checks++; if (o_valid !== 1'b1 || o_irf !== 16'h0400 || o_irepc !== 16'h0000) begin n_fail++; $display("FAIL stream_first_word: got v %0h irf %h pc %h expected v 1 irf 0400 pc 0000", o_valid, o_irf, o_irepc); end
    for (int i = 0; i < 16; i++) step();
    n_checks++; if (ack_addr.size() != 17) begin n_fail++; $display("FAIL stream_ack_count: got %0d expected 17", ack_addr.size()); end
    n_checks++; if (got_pc.size() != 16) begin n_fail++; $display("FAIL stream_pop_count: got %0d expected 16", got_pc.size()); end
    for (int i = 0; i < ack_addr.size(); i++) begin
      n_checks++; if (ack_addr[i] !== 16'(i)) begin n_fail++; $display("FAIL stream_mem_addr[%0d]: got %h expected %h", i, ack_addr[i], 16'(i)); end
    end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_checks++; if (got_pc[i] !== 16'(i) || got_data[i] !== 16'(i) + 16'h0400) begin n_fail++; $display("FAIL stream_word[%0d]: got irf %h pc %h expected irf %h pc %h", i, got_data[i], got_pc[i], 16'(i) + 16'h0400, 16'(i)); end
    end
  endtask

  task automatic test_backpressure();
    data_off = 16'h0462; mem_lat = 0; rand_lat = 0;
    do_reset();
    step(); step(); step();
    n_checks++; if (o_req !== 1'b0 || o_valid !== 1'b1 || o_irf !== 16'h0462 || o_pc !== 16'h0002) begin n_fail++; $display("FAIL bp_full: got req %0h v %0h irf %h pc %h expected req 0 v 1 irf 0462 pc 0002", o_req, o_valid, o_irf, o_pc); end
    n_checks++; if (ack_addr.size() != 2) begin n_fail++; $display("FAIL bp_acks: got %0d expected 2", ack_addr.size()); end
    step();
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got req %0h expected 0", o_req); end
    bus.ire_ready = 1'b1;
    step();
    n_checks++; if (o_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_after_pop: got %0h expected 0", o_req); end
    step();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 16'h0002) begin n_fail++; $display("FAIL bp_resume: got req %0h addr %h expected req 1 addr 0002", o_req, o_addr); end
    for (int i = 0; i < 10; i++) step();
    n_checks++; if (got_pc.size() != 11) begin n_fail++; $display("FAIL bp_pop_count: got %0d expected 11", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      n_checks++; if (got_pc[i] !== 16'(i) || got_data[i] !== 16'(i) + 16'h0462) begin n_fail++; $display("FAIL bp_word[%0d]: got irf %h pc %h expected irf %h pc %h", i, got_data[i], got_pc[i], 16'(i) + 16'h0462, 16'(i)); end
    end
  endtask

  task automatic test_redirect_wait();
    data_off = 16'h0400; mem_lat = 3; rand_lat = 0;
    do_reset();
    bus.ire_ready = 1'b1;
    step(); step();
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
    step();
    bus.redirect = 1'b0;
    n_checks++; if (o_req !== 1'b1 || o_addr !== 16'h0000 || o_pc !== 16'h0040) begin n_fail++; $display("FAIL rw_drain_hold: got req %0h addr %h pc %h expected req 1 addr 0000 pc 0040", o_req, o_addr, o_pc); end
    step();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 16'h0000) begin n_fail++; $display("FAIL rw_drain_hold2: got req %0h addr %h expected req 1 addr 0000", o_req, o_addr); end
    step();
    n_checks++; if (o_req !== 1'b1 || o_addr !== 16'h0040 || o_valid !== 1'b0) begin n_fail++; $display("FAIL rw_after_ack: got req %0h addr %h v %0h expected req 1 addr 0040 v 0", o_req, o_addr, o_valid); end
    for (int i = 0; i < 20 && got_pc.size() == 0; i++) step();
    n_checks++; if (got_pc.size() == 0) begin n_fail++; $display("FAIL rw_timeout: got 0 words expected at least 1"); end
    else begin
      n_checks++; if (got_pc[0] !== 16'h0040 || got_data[0] !== 16'h0440) begin n_fail++; $display("FAIL rw_first_word: got irf %h pc %h expected irf 0440 pc 0040", got_data[0], got_pc[0]); end
    end
  endtask

  task automatic test_redirect_ack_pop();
    logic [15:0] head_pc, rpc;
    int n_before;
    data_off = 16'h0400; mem_lat = 0; rand_lat = 0;
    do_reset();
    bus.ire_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (o_valid !== 1'b1 || o_req !== 1'b1) begin n_fail++; $display("FAIL rap_setup: got v %0h req %0h expected v 1 req 1", o_valid, o_req); end
    head_pc  = o_irepc;
    n_before = got_pc.size();
    rpc = 16'h1230 + 16'($urandom_range(0, 255));
    bus.redirect = 1'b1; bus.redirect_pc = rpc;
    step();
    bus.redirect = 1'b0;
    n_checks++; if (got_pc.size() != n_before + 1 || got_pc[got_pc.size()-1] !== head_pc) begin n_fail++; $display("FAIL rap_pop_delivered: got count %0d last %h expected count %0d last %h", got_pc.size(), got_pc[got_pc.size()-1], n_before + 1, head_pc); end
    n_checks++; if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== rpc || o_pc !== rpc) begin n_fail++; $display("FAIL rap_restart: got v %0h req %0h addr %h pc %h expected v 0 req 1 addr %h pc %h", o_valid, o_req, o_addr, o_pc, rpc, rpc); end
    n_before = got_pc.size();
    for (int i = 0; i < 20 && got_pc.size() < n_before + 3; i++) step();
    n_checks++; if (got_pc.size() < n_before + 3) begin n_fail++; $display("FAIL rap_timeout: got %0d words expected 3", got_pc.size() - n_before); end
    else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (got_pc[n_before+k] !== rpc + 16'(k) || got_data[n_before+k] !== rpc + 16'(k) + 16'h0400) begin n_fail++; $display("FAIL rap_word[%0d]: got irf %h pc %h expected pc %h", k, got_data[n_before+k], got_pc[n_before+k], rpc + 16'(k)); end
      end
    end
  endtask

  task automatic test_wrap();
    int n_before;
    logic [15:0] exp_pc [3];
    exp_pc[0] = 16'hFFFF; exp_pc[1] = 16'h0000; exp_pc[2] = 16'h0001;
    data_off = 16'h0400; mem_lat = 0; rand_lat = 0;
    bus.ire_ready = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFF;
    step();
    bus.redirect = 1'b0;
    n_before = got_pc.size();
    for (int i = 0; i < 20 && got_pc.size() < n_before + 3; i++) step();
    n_checks++; if (got_pc.size() < n_before + 3) begin n_fail++; $display("FAIL wrap_timeout: got %0d words expected 3", got_pc.size() - n_before); end
    else begin
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (got_pc[n_before+k] !== exp_pc[k] || got_data[n_before+k] !== exp_pc[k] + 16'h0400) begin n_fail++; $display("FAIL wrap_word[%0d]: got irf %h pc %h expected irf %h pc %h", k, got_data[n_before+k], got_pc[n_before+k], exp_pc[k] + 16'h0400, exp_pc[k]); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    data_off = 16'h0400; mem_lat = 5; rand_lat = 0;
    do_reset();
    bus.ire_ready = 1'b1;
    bus.redirect_pc = 16'h0077;
    step(); step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_checks++; if (o_req !== 1'b0 || o_pc !== 16'h0000 || o_valid !== 1'b0 || o_addr !== 16'h0000) begin n_fail++; $display("FAIL rmr_reset: got req %0h pc %h v %0h addr %h expected req 0 pc 0000 v 0 addr 0000", o_req, o_pc, o_valid, o_addr); end
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    n_checks++; if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 16'h0000) begin n_fail++; $display("FAIL rmr_stray_ack: got v %0h req %0h addr %h expected v 0 req 1 addr 0000", o_valid, o_req, o_addr); end
    got_data.delete(); got_pc.delete();
    mem_lat = 0;
    for (int i = 0; i < 20 && got_pc.size() == 0; i++) step();
    n_checks++; if (got_pc.size() == 0) begin n_fail++; $display("FAIL rmr_timeout: got 0 words expected at least 1"); end
    else begin
      n_checks++; if (got_pc[0] !== 16'h0000 || got_data[0] !== 16'h0400) begin n_fail++; $display("FAIL rmr_first_word: got irf %h pc %h expected irf 0400 pc 0000", got_data[0], got_pc[0]); end
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_pc, rpc;
    logic        p_req, redir;
    logic [15:0] p_addr;
    int          n_before;
    data_off = 16'($urandom); mem_lat = 0; rand_lat = 1;
    do_reset();
    exp_pc = 16'h0000;
    for (int c = 0; c < 400; c++) begin
      bus.ire_ready = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc = 16'($urandom);
      bus.redirect = redir; bus.redirect_pc = rpc;
      p_req = o_req; p_addr = o_addr;
      n_before = got_pc.size();
      step();
      bus.redirect = 1'b0;
      if (p_req && !bus.mem_ack) begin
        n_checks++; if (o_req !== 1'b1 || o_addr !== p_addr) begin n_fail++; $display("FAIL rnd_req_stable c%0d: got req %0h addr %h expected req 1 addr %h", c, o_req, o_addr, p_addr); end
      end
      for (int k = n_before; k < got_pc.size(); k++) begin
        n_checks++; if (got_pc[k] !== exp_pc || got_data[k] !== exp_pc + data_off) begin n_fail++; $display("FAIL rnd_word c%0d: got irf %h pc %h expected irf %h pc %h", c, got_data[k], got_pc[k], exp_pc + data_off, exp_pc); end
        exp_pc = exp_pc + 16'd1;
      end
      if (redir) exp_pc = rpc;
    end
    rand_lat = 0;
    n_checks++; if (got_pc.size() < 50) begin n_fail++; $display("FAIL rnd_progress: got %0d words expected at least 50", got_pc.size()); end
  endtask

  initial begin
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 16'h0000;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.ire_ready   = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
